// File: rtl/approx_adder_sweep_ctrl.sv
// Exhaustive sweep sequencer for one approximate adder: drives every operand pair, accumulates error statistics
// and grades the result against ET. Optional macro SWEEP_EARLY_ABORT_EN ends the sweep at the first vector with err > ET.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; results hold the previous sweep
// ST_RUN  | a vector is driven; sampled after SETTLE extra cycles
// ST_DONE | one-cycle done pulse, pass is graded on entry
module approx_adder_sweep_ctrl #(
    parameter int IN_W   = 2,
    parameter int ET     = 2,
    parameter int SETTLE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [IN_W-1:0]     op_a,
    output logic [IN_W-1:0]     op_b,
    input  logic [IN_W:0]       dut_sum,
    output logic                pass,
    output logic [2*IN_W:0]     err_count,
    output logic [IN_W:0]       max_err,
    output logic [3*IN_W:0]     sum_abs_err,
    output logic [2*IN_W-1:0]   fail_vec,
    output logic                fail_seen
);

    localparam int OUT_W = IN_W + 1;
    localparam int VEC_W = 2 * IN_W;
    localparam int CNT_W = 2 * IN_W + 1;
    localparam int SUM_W = 3 * IN_W + 1;
    localparam logic [OUT_W-1:0] ET_V     = OUT_W'(ET);
    localparam logic [3:0]       SETTLE_V = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [3:0]         wait_q, wait_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [OUT_W-1:0]   max_err_q, max_err_d;
    logic [SUM_W-1:0]   sum_abs_err_q, sum_abs_err_d;
    logic [VEC_W-1:0]   fail_vec_q, fail_vec_d;
    logic               fail_seen_q, fail_seen_d;
    logic               pass_q, pass_d;
    logic               last_vec;

    logic [OUT_W-1:0]   exact;
    logic [OUT_W:0]     diff_u;
    logic [OUT_W:0]     abs_diff;
    logic [OUT_W-1:0]   err;

    assign op_a = vec_q[IN_W-1:0];
    assign op_b = vec_q[VEC_W-1:IN_W];

    // One extra bit keeps the borrow so the sign of dut_sum - exact is visible.
    assign exact    = OUT_W'(op_a) + OUT_W'(op_b);
    assign diff_u   = {1'b0, dut_sum} - {1'b0, exact};
    assign abs_diff = diff_u[OUT_W] ? ('0 - diff_u) : diff_u;
    assign err      = abs_diff[OUT_W-1:0];

    always_comb begin
        state_d       = state_q;
        vec_d         = vec_q;
        wait_d        = wait_q;
        err_count_d   = err_count_q;
        max_err_d     = max_err_q;
        sum_abs_err_d = sum_abs_err_q;
        fail_vec_d    = fail_vec_q;
        fail_seen_d   = fail_seen_q;
        pass_d        = pass_q;
        last_vec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_RUN;
                    vec_d         = '0;
                    wait_d        = '0;
                    err_count_d   = '0;
                    max_err_d     = '0;
                    sum_abs_err_d = '0;
                    fail_vec_d    = '0;
                    fail_seen_d   = 1'b0;
                    pass_d        = 1'b1;
                end
            end
            ST_RUN: begin
                if (wait_q != SETTLE_V) begin
                    wait_d = wait_q + 4'd1;
                end else begin
                    wait_d = '0;
                    if (err != '0)
                        err_count_d = err_count_q + CNT_W'(1);
                    if (err > max_err_q)
                        max_err_d = err;
                    sum_abs_err_d = sum_abs_err_q + SUM_W'(err);
                    if (err > ET_V && !fail_seen_q) begin
                        fail_seen_d = 1'b1;
                        fail_vec_d  = vec_q;
                    end
                    last_vec = &vec_q;
`ifdef SWEEP_EARLY_ABORT_EN
                    if (err > ET_V)
                        last_vec = 1'b1;
`else
                    last_vec = last_vec | 1'b0;
`endif
                    if (last_vec) begin
                        state_d = ST_DONE;
                        pass_d  = (max_err_d <= ET_V);
                    end else begin
                        vec_d = vec_q + VEC_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            vec_q         <= '0;
            wait_q        <= '0;
            err_count_q   <= '0;
            max_err_q     <= '0;
            sum_abs_err_q <= '0;
            fail_vec_q    <= '0;
            fail_seen_q   <= 1'b0;
            pass_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            vec_q         <= vec_d;
            wait_q        <= wait_d;
            err_count_q   <= err_count_d;
            max_err_q     <= max_err_d;
            sum_abs_err_q <= sum_abs_err_d;
            fail_vec_q    <= fail_vec_d;
            fail_seen_q   <= fail_seen_d;
            pass_q        <= pass_d;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign pass        = pass_q;
    assign err_count   = err_count_q;
    assign max_err     = max_err_q;
    assign sum_abs_err = sum_abs_err_q;
    assign fail_vec    = fail_vec_q;
    assign fail_seen   = fail_seen_q;

endmodule

// File: doc/approx_adder_sweep_ctrl.md
# approx_adder_sweep_ctrl

Sequencer that exhaustively characterises one approximate adder instance produced by the approximate-synthesis flow. It walks every operand pair, drives the adder-under-test's operand inputs, and compares the returned sum against the exact sum. It accumulates error statistics and reports pass/fail against the error threshold (ET) the circuit was synthesised for. It sits between a test/calibration host and one approximate adder netlist, which stays external and purely combinational or multicycle.

## Interface
- IN_W, 2: width of each operand; the adder output is OUT_W = IN_W+1 bits.
- ET, 2: maximum allowed absolute error; unsigned, OUT_W bits.
- SETTLE, 0: extra wait cycles per vector before sampling, for a multicycle adder (0..15).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- busy  out  1  high while a sweep runs.
- done  out  1  one-cycle pulse when a sweep finishes.
- op_a  out  IN_W  operand A to the adder.
- op_b  out  IN_W  operand B to the adder.
- dut_sum  in  OUT_W  approximate sum returned by the adder.
- pass  out  1  max_err <= ET; valid from done onward.
- err_count  out  2*IN_W+1  number of vectors with a nonzero error.
- max_err  out  OUT_W  largest absolute error seen.
- sum_abs_err  out  3*IN_W+1  sum of absolute errors over the vectors evaluated.
- fail_vec  out  2*IN_W  first vector index whose error exceeded ET; 0 if none.
- fail_seen  out  1  at least one vector exceeded ET.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. Result outputs hold the previous sweep's values.
- IDLE and start=1: clear all statistics, fail_seen and fail_vec. Set vec=0 and wait=0, then go to RUN.
- Vector index vec is 2*IN_W bits wide. op_a = vec[IN_W-1:0] and op_b = vec[2*IN_W-1:IN_W]; both are driven from registers.
- RUN, wait < SETTLE: increment wait. No sampling takes place.
- RUN, wait == SETTLE: sample dut_sum and compute exact = op_a + op_b, zero-extended to OUT_W bits.
  - err = |dut_sum - exact|, computed in OUT_W+1 bits signed, result OUT_W bits.
  - err != 0: increment err_count.
  - max_err = max(max_err, err).
  - sum_abs_err += err.
  - err > ET and fail_seen=0: set fail_seen=1 and fail_vec=vec.
  - Then set wait=0. If vec is all-ones, go to DONE; otherwise increment vec.
- DONE: done=1 for exactly one cycle, then go to IDLE. pass = (max_err <= ET) and stays registered until the next start.
- start while in RUN or DONE is ignored; no queueing.
- Accumulators cannot overflow at the stated widths. Do not add saturation logic.
- rst_n=0 in any state aborts the sweep and forces the reset values on the next edge.

## Timing
- Reset values: state=IDLE, busy=0, done=0, op_a=0, op_b=0, err_count=0, max_err=0, sum_abs_err=0, fail_vec=0, fail_seen=0, pass=1.
- start sampled at edge k puts the block in RUN, with busy=1 and op_a=op_b=0 visible after edge k.
- Each vector is held for SETTLE+1 cycles. dut_sum is sampled at the last edge of that hold window.
- The final vector is evaluated at edge k + 2^(2*IN_W)*(SETTLE+1). done=1 and busy=0 in the following cycle.
- busy and done are never high together.

## Configuration
- SWEEP_EARLY_ABORT_EN defined: the first vector with err > ET updates the statistics for that vector, then goes directly to DONE with pass=0. The remaining vectors are not evaluated.
- SWEEP_EARLY_ABORT_EN undefined: the full sweep always runs. fail_vec records the first exceeding vector only.

## Test plan
- Exact adder model (dut_sum = op_a + op_b), IN_W=2, SETTLE=0, ET=2, start at edge 0 -> busy for 16 cycles, done at cycle 17; err_count=0, max_err=0, sum_abs_err=0, pass=1, fail_seen=0.
- dut_sum tied to 0, no abort macro -> err_count=15, max_err=6, sum_abs_err=48, fail_vec=3 (a=3, b=0), fail_seen=1, pass=0.
- Same stimulus with SWEEP_EARLY_ABORT_EN defined -> done after vec 3 is evaluated; err_count=3, max_err=3, sum_abs_err=6, fail_vec=3, pass=0.
- SETTLE=2, exact model -> op_a/op_b change every 3 cycles; done 48 cycles after start; pass=1.
- Pulse start again mid-sweep -> ignored, counters unaffected. Assert rst_n=0 at vector 7 -> next cycle IDLE with all reset values; a later start re-runs from vec=0.
- dut_sum = exact+1 for vec 5 only, ET=0 -> err_count=1, max_err=1, fail_vec=5, pass=0.
